snoop_filter_ctrl: RTL and testbench
====================================

Name: snoop_filter_ctrl

Overview:
- Registered, parametrised inclusive snoop filter for the coherent interconnect home node.
- Tracks which request nodes (RNs) hold each cached line, using per-entry tag, valid bit and presence vector.
- For every accepted request it returns the snoop target mask for the other RNs and updates presence.
- Allocates on read misses; when full, evicts a victim round-robin and reports the victim's tag and holders for back-invalidation.
- Generalises the fixed 4-RN, 64-entry combinational filter with a clocked pipeline, valid/ready handshakes, eviction reporting and occupancy tracking.

Parameters:
- TAG_W, 33, tag width in bits.
- ENTRIES, 64, number of filter entries (≥2).
- NUM_RN, 4, number of tracked request nodes (1..16).
- RN_W, $clog2(NUM_RN) (minimum 1), width of the requester index.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  filter can accept a request.
- req_tag  in  TAG_W  line tag.
- req_opcode  in  7  0x01 READ_SHARED, 0x07 READ_UNIQUE, 0x1B WRITE_BACK_FULL; all other values are no-ops.
- req_rn  in  RN_W  requester index.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_hit  out  1  tag matched a valid entry.
- rsp_snoop_mask  out  NUM_RN  RNs to snoop.
- rsp_evict  out  1  a victim was displaced.
- rsp_evict_tag  out  TAG_W  victim tag.
- rsp_evict_mask  out  NUM_RN  victim presence vector (back-invalidate targets).
- occupancy  out  $clog2(ENTRIES+1)  count of valid entries.

Behaviour:
- Reset:
  - All entries invalid, round-robin pointer 0, state IDLE.
  - rsp_valid, rsp_hit, rsp_evict = 0; all masks and evict_tag = 0; occupancy = 0; req_ready = 0 while reset is high.
  - Reset mid-operation drops any in-flight request with no response.
- State machine IDLE -> LOOKUP -> RESP -> IDLE:
  - IDLE: req_ready = 1. On req_valid & req_ready, capture tag/opcode/rn and go to LOOKUP.
  - LOOKUP (1 cycle): compare the captured tag against all valid entries. Compute hit index, lowest-index invalid entry, and victim = pointer. Update the entry array and occupancy. Register the response fields. Go to RESP.
  - RESP: rsp_valid = 1 and all rsp_* fields held stable until rsp_ready. On the handshake go to IDLE.
- Timing: rsp_valid rises 2 cycles after request acceptance. Best-case throughput is one request per 3 cycles.
- Notation: b = one-hot(req_rn); P = presence vector of the hit entry.
- Hit, READ_SHARED: mask = P & ~b; P |= b.
- Hit, READ_UNIQUE: mask = P & ~b; P = b.
- Hit, WRITE_BACK_FULL: mask = 0; P &= ~b. If P becomes 0, the entry is invalidated and occupancy decrements.
- Hit, other opcode: mask = 0, no state change. rsp_hit = 1 on every hit.
- Miss, READ_SHARED or READ_UNIQUE:
  - mask = 0; allocate the entry with valid = 1, tag, P = b.
  - Free entry exists: use the lowest-index invalid entry, occupancy +1, rsp_evict = 0, pointer unchanged.
  - Full: replace entry[pointer]. rsp_evict = 1, evict_tag and evict_mask taken from the old entry. Pointer = (pointer + 1) mod ENTRIES, wrapping from ENTRIES-1 to 0. Occupancy unchanged.
- Miss, WRITE_BACK_FULL or other opcode: mask = 0, no allocation, rsp_hit = 0.
- req_rn ≥ NUM_RN: treated as a no-op opcode (response still issued, mask 0, no state change).
- Entry invariants: at most one valid entry per tag; a valid entry never has P = 0.
- Responses with rsp_evict = 0 drive evict_tag and evict_mask to 0.
- rsp_ready held low: the filter stalls in RESP and req_ready stays 0; no requests are lost.

Test Plan:
- Reset, then READ_SHARED tag 0x1_0000_0040 from rn 0 -> rsp_hit 0, mask 0000, evict 0, occupancy 1, rsp_valid exactly 2 cycles after acceptance.
- Same tag READ_SHARED from rn 2, then READ_UNIQUE from rn 3 -> first response mask 0001; second response mask 0101, P becomes 1000.
- WRITE_BACK_FULL from rn 3 on that line -> mask 0000, hit 1; entry freed, occupancy drops by 1; a subsequent READ_SHARED from rn 1 misses.
- Fill all 64 entries with distinct tags, then a 65th READ_UNIQUE -> evict 1, evict_tag = entry 0's tag, evict_mask = its P; repeat 64 more misses -> pointer wraps and entry 0 is victimised again.
- Hold rsp_ready low for 5 cycles with req_valid high -> response fields stable, req_ready 0 throughout; the next request is accepted 1 cycle after the handshake.
- Assert reset while in LOOKUP -> no rsp_valid, occupancy 0; the previously allocated tag misses afterwards.

Source files
------------

// File: rtl/snoop_filter_ctrl.sv
// Inclusive snoop filter for the home node: tracks which request nodes hold each line,
// returns snoop targets per request and reports round-robin victims for back-invalidation.
module snoop_filter_ctrl #(
  parameter int TAG_W   = 33,
  parameter int ENTRIES = 64,
  parameter int NUM_RN  = 4,
  parameter int RN_W    = (NUM_RN > 1) ? $clog2(NUM_RN) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [TAG_W-1:0]             req_tag,
  input  logic [6:0]                   req_opcode,
  input  logic [RN_W-1:0]              req_rn,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_hit,
  output logic [NUM_RN-1:0]            rsp_snoop_mask,
  output logic                         rsp_evict,
  output logic [TAG_W-1:0]             rsp_evict_tag,
  output logic [NUM_RN-1:0]            rsp_evict_mask,
  output logic [$clog2(ENTRIES+1)-1:0] occupancy
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int OCC_W = $clog2(ENTRIES + 1);

  localparam logic [6:0] OP_READ_SHARED = 7'h01;
  localparam logic [6:0] OP_READ_UNIQUE = 7'h07;
  localparam logic [6:0] OP_WRITE_BACK  = 7'h1B;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // rsp_* fields stay stable from rsp_valid rising until that transfer.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_next;

  logic              valid_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [NUM_RN-1:0] pres_q  [ENTRIES];
  logic [IDX_W-1:0]  ptr_q;
  logic [OCC_W-1:0]  occ_q;

  logic [TAG_W-1:0]  cap_tag;
  logic [6:0]        cap_opcode;
  logic [RN_W-1:0]   cap_rn;

  logic              hit_q;
  logic [NUM_RN-1:0] mask_q;
  logic              evict_q;
  logic [TAG_W-1:0]  evict_tag_q;
  logic [NUM_RN-1:0] evict_mask_q;

  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic [NUM_RN-1:0] rn_onehot;
  logic [NUM_RN-1:0] hit_pres;
  logic [NUM_RN-1:0] wb_pres;
  logic              rn_ok;
  logic              is_rs, is_ru, is_wb;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !reset;
        if (req_valid && !reset) state_next = LOOKUP;
      end
      LOOKUP: state_next = RESP;
      RESP: begin
        rsp_valid = !reset;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // An out-of-range requester decodes to an all-zero one-hot and behaves as a no-op.
  always_comb begin
    rn_onehot = '0;
    for (int i = 0; i < NUM_RN; i++) begin
      if (cap_rn == RN_W'(i)) rn_onehot[i] = 1'b1;
    end
  end

  assign rn_ok = |rn_onehot;
  assign is_rs = rn_ok && (cap_opcode == OP_READ_SHARED);
  assign is_ru = rn_ok && (cap_opcode == OP_READ_UNIQUE);
  assign is_wb = rn_ok && (cap_opcode == OP_WRITE_BACK);

  // Scanning downwards leaves the lowest matching index in each result.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == cap_tag)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign hit_pres = pres_q[hit_idx];
  assign wb_pres  = hit_pres & ~rn_onehot;

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_tag    <= '0;
      cap_opcode <= '0;
      cap_rn     <= '0;
    end else if (state == IDLE && req_valid) begin
      cap_tag    <= req_tag;
      cap_opcode <= req_opcode;
      cap_rn     <= req_rn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        pres_q[i]  <= '0;
      end
      ptr_q        <= '0;
      occ_q        <= '0;
      hit_q        <= 1'b0;
      mask_q       <= '0;
      evict_q      <= 1'b0;
      evict_tag_q  <= '0;
      evict_mask_q <= '0;
    end else if (state == LOOKUP) begin
      hit_q        <= hit;
      mask_q       <= '0;
      evict_q      <= 1'b0;
      evict_tag_q  <= '0;
      evict_mask_q <= '0;
      if (hit) begin
        if (is_rs) begin
          mask_q          <= hit_pres & ~rn_onehot;
          pres_q[hit_idx] <= hit_pres | rn_onehot;
        end else if (is_ru) begin
          mask_q          <= hit_pres & ~rn_onehot;
          pres_q[hit_idx] <= rn_onehot;
        end else if (is_wb) begin
          pres_q[hit_idx] <= wb_pres;
          if (wb_pres == '0) begin
            valid_q[hit_idx] <= 1'b0;
            occ_q            <= occ_q - OCC_W'(1);
          end
        end
      end else if (is_rs || is_ru) begin
        if (free_found) begin
          valid_q[free_idx] <= 1'b1;
          tag_q[free_idx]   <= cap_tag;
          pres_q[free_idx]  <= rn_onehot;
          occ_q             <= occ_q + OCC_W'(1);
        end else begin
          evict_q        <= 1'b1;
          evict_tag_q    <= tag_q[ptr_q];
          evict_mask_q   <= pres_q[ptr_q];
          tag_q[ptr_q]   <= cap_tag;
          pres_q[ptr_q]  <= rn_onehot;
          ptr_q          <= (ptr_q == IDX_W'(ENTRIES - 1)) ? '0 : ptr_q + IDX_W'(1);
        end
      end
    end
  end

  assign rsp_hit        = hit_q;
  assign rsp_snoop_mask = mask_q;
  assign rsp_evict      = evict_q;
  assign rsp_evict_tag  = evict_tag_q;
  assign rsp_evict_mask = evict_mask_q;
  assign occupancy      = occ_q;

endmodule

// File: tb/tb_snoop_filter_ctrl.sv
// Self-checking bench for snoop_filter_ctrl: directed scenarios plus random traffic
// compared against a table-based model of the filter's line-ownership rules.
module tb_snoop_filter_ctrl;

  localparam int TAG_W   = 33;
  localparam int ENTRIES = 64;
  localparam int NUM_RN  = 4;
  localparam int RN_W    = 2;
  localparam int OCC_W   = $clog2(ENTRIES + 1);

  localparam logic [6:0] RS = 7'h01;
  localparam logic [6:0] RU = 7'h07;
  localparam logic [6:0] WB = 7'h1B;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [TAG_W-1:0]  req_tag;
  logic [6:0]        req_opcode;
  logic [RN_W-1:0]   req_rn;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_hit;
  logic [NUM_RN-1:0] rsp_snoop_mask;
  logic              rsp_evict;
  logic [TAG_W-1:0]  rsp_evict_tag;
  logic [NUM_RN-1:0] rsp_evict_mask;
  logic [OCC_W-1:0]  occupancy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a table of lines, each with its tag and holder set.
  bit                m_valid [ENTRIES];
  logic [TAG_W-1:0]  m_tag   [ENTRIES];
  logic [NUM_RN-1:0] m_pres  [ENTRIES];
  int                m_ptr;
  int                m_occ;

  logic [TAG_W-1:0]  pool [80];

  snoop_filter_ctrl #(.TAG_W(TAG_W), .ENTRIES(ENTRIES), .NUM_RN(NUM_RN)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_tag        (req_tag),
    .req_opcode     (req_opcode),
    .req_rn         (req_rn),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_hit        (rsp_hit),
    .rsp_snoop_mask (rsp_snoop_mask),
    .rsp_evict      (rsp_evict),
    .rsp_evict_tag  (rsp_evict_tag),
    .rsp_evict_mask (rsp_evict_mask),
    .occupancy      (occupancy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = '0;
      m_pres[i]  = '0;
    end
    m_ptr = 0;
    m_occ = 0;
  endfunction

  function automatic void model_step(
    input  logic [TAG_W-1:0]  t,
    input  logic [6:0]        op,
    input  int                rn,
    output logic              e_hit,
    output logic [NUM_RN-1:0] e_mask,
    output logic              e_ev,
    output logic [TAG_W-1:0]  e_et,
    output logic [NUM_RN-1:0] e_em
  );
    int idx;
    int slot;
    logic [NUM_RN-1:0] b;
    idx = -1;
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && m_tag[i] == t) idx = i;
    e_hit  = (idx >= 0);
    e_mask = '0;
    e_ev   = 1'b0;
    e_et   = '0;
    e_em   = '0;
    if (rn >= NUM_RN) return;
    b = '0;
    b[rn] = 1'b1;
    if (idx >= 0) begin
      if (op == RS) begin
        e_mask = m_pres[idx] & ~b;
        m_pres[idx] = m_pres[idx] | b;
      end else if (op == RU) begin
        e_mask = m_pres[idx] & ~b;
        m_pres[idx] = b;
      end else if (op == WB) begin
        m_pres[idx] = m_pres[idx] & ~b;
        if (m_pres[idx] == '0) begin
          m_valid[idx] = 0;
          m_occ--;
        end
      end
    end else if (op == RS || op == RU) begin
      if (m_occ < ENTRIES) begin
        slot = ENTRIES;
        for (int i = ENTRIES - 1; i >= 0; i--)
          if (!m_valid[i]) slot = i;
        m_occ++;
      end else begin
        slot  = m_ptr;
        e_ev  = 1'b1;
        e_et  = m_tag[slot];
        e_em  = m_pres[slot];
        m_ptr = (m_ptr + 1) % ENTRIES;
      end
      m_valid[slot] = 1;
      m_tag[slot]   = t;
      m_pres[slot]  = b;
    end
  endfunction

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("reset_req_ready", req_ready, 0);
      check("reset_rsp_valid", rsp_valid, 0);
    end
    check("reset_occupancy", occupancy, 0);
    check("reset_hit", rsp_hit, 0);
    check("reset_evict", rsp_evict, 0);
    check("reset_masks", {rsp_snoop_mask, rsp_evict_mask}, 0);
    check("reset_evict_tag", rsp_evict_tag, 0);
    reset = 1'b0;
    model_clear();
  endtask

  // Driver: one full request/response transaction, optionally stalling the response.
  task automatic do_req(input logic [TAG_W-1:0] t, input logic [6:0] op,
                        input logic [RN_W-1:0] rn, input int stall);
    logic              e_hit, e_ev;
    logic [NUM_RN-1:0] e_mask, e_em;
    logic [TAG_W-1:0]  e_et;
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_tag = t;
    req_opcode = op;
    req_rn = rn;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    model_step(t, op, int'(rn), e_hit, e_mask, e_ev, e_et, e_em);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rsp_latency", n, 2);
    if (!rsp_valid) return;
    for (int s = 0; s <= stall; s++) begin
      check("rsp_hit", rsp_hit, e_hit);
      check("rsp_snoop_mask", rsp_snoop_mask, e_mask);
      check("rsp_evict", rsp_evict, e_ev);
      check("rsp_evict_tag", rsp_evict_tag, e_et);
      check("rsp_evict_mask", rsp_evict_mask, e_em);
      check("occupancy", occupancy, m_occ);
      check("req_ready_in_resp", req_ready, 0);
      if (s < stall) begin
        check("rsp_valid_stall", rsp_valid, 1);
        req_valid = 1'b1;
        req_tag = ~t;
        @(negedge clk);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_after_hs", rsp_valid, 0);
    check("req_ready_after_hs", req_ready, 1);
  endtask

  initial begin
    logic [TAG_W-1:0] line;
    logic [6:0]       ops [5];
    reset = 1'b1;
    req_valid = 1'b0;
    req_tag = '0;
    req_opcode = '0;
    req_rn = '0;
    rsp_ready = 1'b0;
    ops[0] = RS; ops[1] = RU; ops[2] = WB; ops[3] = 7'h05; ops[4] = RS;

    do_reset(3);

    // Sharing, upgrade and write-back on one line
    line = 33'h1_0000_0040;
    do_req(line, RS, 2'd0, 0);
    do_req(line, RS, 2'd2, 0);
    do_req(line, RU, 2'd3, 0);
    do_req(line, WB, 2'd3, 0);
    do_req(line, RS, 2'd1, 0);
    do_req(line, 7'h2A, 2'd2, 0);
    do_req(33'h0_1234_5678, WB, 2'd0, 0);

    // Fill, then two full rounds of victims so the pointer wraps
    do_reset(2);
    for (int i = 0; i < ENTRIES; i++)
      do_req({1'b0, 32'hA000_0000 + 32'(i)}, ($urandom_range(0, 1) != 0) ? RU : RS,
             RN_W'($urandom_range(0, NUM_RN - 1)), 0);
    for (int i = 0; i <= ENTRIES; i++)
      do_req({1'b1, 32'hB000_0000 + 32'(i)}, RU, RN_W'($urandom_range(0, NUM_RN - 1)), 0);

    // Random traffic over a small tag pool to mix hits, misses, frees and evictions
    for (int i = 0; i < 80; i++) pool[i] = {$urandom_range(0, 1) == 1, $urandom};
    for (int i = 0; i < 300; i++)
      do_req(pool[$urandom_range(0, 79)], ops[$urandom_range(0, 4)],
             RN_W'($urandom_range(0, NUM_RN - 1)), ($urandom_range(0, 9) == 0) ? 2 : 0);

    // Back-pressure on the response
    do_req(33'h0_00C0_FFEE, RS, 2'd1, 5);
    do_req(33'h0_00C0_FFEE, RS, 2'd2, 0);

    // Reset while a request sits in LOOKUP
    do_reset(2);
    do_req(33'h1_5555_0000, RS, 2'd0, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_tag = 33'h0_7777_0000;
    req_opcode = RU;
    req_rn = 2'd1;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("lookup_reset_rsp_valid", rsp_valid, 0);
    check("lookup_reset_occupancy", occupancy, 0);
    @(negedge clk);
    check("lookup_reset_rsp_valid2", rsp_valid, 0);
    reset = 1'b0;
    model_clear();
    do_req(33'h1_5555_0000, RS, 2'd0, 0);
    do_req(33'h0_7777_0000, RS, 2'd1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
